// File: rtl/arp_cache_pkg.sv
// ============================================================================
//  arp_cache_pkg
//  Shared types and constants for the ARP cache controller.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package arp_cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TX_REPLY  = 3'd1,
    ST_TX_REQ    = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_WAIT_RESP = 3'd4
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] ip;
    logic [47:0] mac;
  } cache_entry_t;

  localparam logic [47:0] BROADCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic        ARP_REQUEST   = 1'b0;
  localparam logic        ARP_REPLY     = 1'b1;

endpackage

`default_nettype wire

// File: rtl/arp_cache_mem.sv
// ============================================================================
//  arp_cache_mem
//  IP->MAC storage with in-place update, round-robin replacement and an
//  optional per-entry lifetime (compile with ARP_CACHE_AGING_EN).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module arp_cache_mem
  import arp_cache_pkg::*;
#(
  parameter int          ENTRIES    = 4,
  parameter logic [31:0] AGE_CYCLES = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_ip,
  input  logic [47:0] wr_mac,
  input  logic [31:0] rd_ip,
  output logic        rd_hit,
  output logic [47:0] rd_mac
);

  localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  cache_entry_t       entries [ENTRIES];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   match_idx;
  logic               wr_match;
  logic [ENTRIES-1:0] wr_sel;

  always_comb begin
    wr_match  = 1'b0;
    match_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!wr_match && entries[i].valid && entries[i].ip == wr_ip) begin
        wr_match  = 1'b1;
        match_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      wr_sel[i] = wr_en && (wr_match ? (match_idx == PTR_W'(i)) : (wr_ptr == PTR_W'(i)));
    end
  end

  // A write landing this cycle is forwarded so a same-cycle lookup sees it.
  always_comb begin
    rd_hit = 1'b0;
    rd_mac = '0;
    if (wr_en && wr_ip == rd_ip) begin
      rd_hit = 1'b1;
      rd_mac = wr_mac;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (!rd_hit && entries[i].valid && entries[i].ip == rd_ip) begin
          rd_hit = 1'b1;
          rd_mac = entries[i].mac;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      wr_ptr <= '0;
    else if (wr_en && !wr_match)
      wr_ptr <= wr_ptr + 1'b1;
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    cache_entry_t ent;
`ifdef ARP_CACHE_AGING_EN
    logic [31:0] age;
    always_ff @(posedge clk) begin
      if (rst) begin
        ent <= '0;
        age <= '0;
      end else if (wr_sel[i]) begin
        ent <= '{valid: 1'b1, ip: wr_ip, mac: wr_mac};
        age <= '0;
      end else if (ent.valid) begin
        if (age == AGE_CYCLES - 32'd1)
          ent.valid <= 1'b0;
        else
          age <= age + 32'd1;
      end
    end
`else
    always_ff @(posedge clk) begin
      if (rst)
        ent <= '0;
      else if (wr_sel[i])
        ent <= '{valid: 1'b1, ip: wr_ip, mac: wr_mac};
    end
`endif
    assign entries[i] = ent;
  end

`ifndef ARP_CACHE_AGING_EN
  // Entries never expire in this build; the lifetime only shapes the aging build.
  if (AGE_CYCLES == 32'd0) begin : g_no_lifetime
  end
`endif

endmodule

`default_nettype wire

// File: rtl/arp_cache_ctrl.sv
// ============================================================================
//  arp_cache_ctrl
//  ARP cache with request answering and miss resolution with retries.
//  Optional entry aging: define ARP_CACHE_AGING_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module arp_cache_ctrl
  import arp_cache_pkg::*;
#(
  parameter int          ENTRIES      = 4,
  parameter int          RETRY_CYCLES = 125_000_000,
  parameter int          MAX_RETRY    = 3,
  parameter logic [31:0] AGE_CYCLES   = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arp_rx_done,
  input  logic        arp_rx_type,
  input  logic [47:0] src_mac,
  input  logic [31:0] src_ip,
  output logic        arp_tx_en,
  output logic        arp_tx_type,
  output logic [47:0] des_mac,
  output logic [31:0] des_ip,
  input  logic        tx_done,
  input  logic        lookup_req,
  input  logic [31:0] lookup_ip,
  output logic        lookup_ack,
  output logic        lookup_hit,
  output logic [47:0] lookup_mac,
  output logic        resolve_busy,
  output logic        resolve_fail
);

  localparam logic [31:0] RETRY_LAST = 32'(RETRY_CYCLES - 1);
  localparam logic [31:0] RETRY_MAX  = 32'(MAX_RETRY);

  state_t      state, next_state;
  logic        pend_valid, waiting_resp;
  logic [47:0] pend_mac;
  logic [31:0] pend_ip, target_ip, retry_cnt, attempts;
  logic        load_reply, load_req, resolved, fail, retry_tick;
  logic        cache_hit, start_resolve;
  logic [47:0] cache_mac;

  arp_cache_mem #(
    .ENTRIES    (ENTRIES),
    .AGE_CYCLES (AGE_CYCLES)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (arp_rx_done),
    .wr_ip  (src_ip),
    .wr_mac (src_mac),
    .rd_ip  (lookup_ip),
    .rd_hit (cache_hit),
    .rd_mac (cache_mac)
  );

  assign arp_tx_en     = (state == ST_TX_REPLY) || (state == ST_TX_REQ);
  assign start_resolve = lookup_req && !cache_hit && !resolve_busy;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_reply = 1'b0;
    load_req   = 1'b0;
    resolved   = 1'b0;
    fail       = 1'b0;
    retry_tick = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pend_valid) begin
          load_reply = 1'b1;
          next_state = ST_TX_REPLY;
        end else if (resolve_busy) begin
          load_req   = 1'b1;
          next_state = ST_TX_REQ;
        end
      end
      ST_TX_REPLY, ST_TX_REQ: next_state = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (tx_done) next_state = waiting_resp ? ST_WAIT_RESP : ST_IDLE;
      end
      ST_WAIT_RESP: begin
        if (arp_rx_done && arp_rx_type == ARP_REPLY && src_ip == target_ip) begin
          resolved   = 1'b1;
          next_state = ST_IDLE;
        end else if (pend_valid) begin
          // Retry timer is frozen, not cleared, while the reply goes out.
          load_reply = 1'b1;
          next_state = ST_TX_REPLY;
        end else if (retry_cnt == RETRY_LAST) begin
          if (attempts < RETRY_MAX) begin
            load_req   = 1'b1;
            next_state = ST_TX_REQ;
          end else begin
            fail       = 1'b1;
            next_state = ST_IDLE;
          end
        end else begin
          retry_tick = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arp_tx_type  <= ARP_REQUEST;
      des_mac      <= '0;
      des_ip       <= '0;
      lookup_ack   <= 1'b0;
      lookup_hit   <= 1'b0;
      lookup_mac   <= '0;
      resolve_busy <= 1'b0;
      resolve_fail <= 1'b0;
      pend_valid   <= 1'b0;
      pend_mac     <= '0;
      pend_ip      <= '0;
      target_ip    <= '0;
      waiting_resp <= 1'b0;
      retry_cnt    <= '0;
      attempts     <= '0;
    end else begin
      lookup_ack   <= lookup_req;
      lookup_hit   <= lookup_req && cache_hit;
      lookup_mac   <= (lookup_req && cache_hit) ? cache_mac : '0;
      resolve_fail <= fail;

      if (arp_rx_done && arp_rx_type == ARP_REQUEST) begin
        pend_valid <= 1'b1;
        pend_mac   <= src_mac;
        pend_ip    <= src_ip;
      end else if (load_reply) begin
        pend_valid <= 1'b0;
      end

      if (load_reply) begin
        arp_tx_type <= ARP_REPLY;
        des_mac     <= pend_mac;
        des_ip      <= pend_ip;
      end
      if (load_req) begin
        arp_tx_type  <= ARP_REQUEST;
        des_mac      <= BROADCAST_MAC;
        des_ip       <= target_ip;
        attempts     <= attempts + 32'd1;
        retry_cnt    <= '0;
        waiting_resp <= 1'b1;
      end
      if (retry_tick) retry_cnt <= retry_cnt + 32'd1;
      if (resolved || fail) begin
        resolve_busy <= 1'b0;
        waiting_resp <= 1'b0;
      end
      if (start_resolve) begin
        resolve_busy <= 1'b1;
        target_ip    <= lookup_ip;
        attempts     <= '0;
        retry_cnt    <= '0;
      end
    end
  end

endmodule

`default_nettype wire
